tpi_link_xfer: RTL and testbench
================================

Name: tpi_link_xfer

Overview:
- Byte-transfer engine for the parallel drive link. It sits directly downstream of the TPI port A and port C pins.
- Converts the 4-phase DAV/ACK handshake on those pins into a host-side streaming interface: a TX FIFO in and a single-entry RX holding register out.
- Half-duplex: one shared 8-bit data path with an output enable.
- Per-phase timeout with a sticky error flag.

Parameters:
- TX_DEPTH, 4, TX FIFO depth in bytes; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 1024, maximum clock cycles spent in any waiting state before abort; minimum 4.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  FIFO not full; push occurs when tx_valid & tx_ready
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer takes the byte when rx_valid & rx_ready
- link_din  in  8  sampled port A pin levels
- link_dout  out  8  value driven onto port A
- link_oe  out  1  port A drive enable
- dav_out  out  1  data-available strobe to peer (active-high here; pin inversion is done elsewhere)
- ack_in  in  1  peer acknowledge (asynchronous)
- dav_in  in  1  peer data-available (asynchronous)
- ack_out  out  1  acknowledge to peer
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky timeout flag
- err_clear  in  1  clears timeout_err

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE; FIFO empty.
  - tx_ready=1; rx_valid=0; rx_data=0.
  - link_oe=0; link_dout=0; dav_out=0; ack_out=0.
  - busy=0; timeout_err=0.
- A reset asserted mid-transfer aborts immediately to these values. FIFO contents are lost.
- Synchronisers: ack_in and dav_in each pass through 2 flops, giving ack_s and dav_s. All decisions use only ack_s and dav_s.
- Every output is registered.
- FIFO push and pop:
  - A push on a full FIFO cannot occur, because tx_ready=0 when full.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - Pointers wrap modulo TX_DEPTH.
- States:
  - IDLE
    - If dav_s=1 and rx_valid=0: latch link_din into rx_data, set rx_valid=1, ack_out=1, go to RX_WAIT_REL.
    - Otherwise, if dav_s=0 and the FIFO is non-empty: go to TX_SETUP.
    - RX has priority when both conditions hold.
    - If dav_s=1 and rx_valid=1: stay in IDLE with no ack (backpressure) and never start TX. No timeout applies in IDLE.
  - TX_SETUP (1 cycle)
    - link_oe=1; link_dout=FIFO head; dav_out=0. Then go to TX_WAIT_ACK.
  - TX_WAIT_ACK
    - link_oe=1; dav_out=1.
    - On ack_s=1: dav_out=0, go to TX_WAIT_REL.
  - TX_WAIT_REL
    - link_oe=1; dav_out=0.
    - On ack_s=0: pop FIFO, link_oe=0, go to IDLE.
  - RX_WAIT_REL
    - ack_out=1.
    - On dav_s=0: ack_out=0, go to IDLE.
- Latency (TX): a push at edge N with FIFO empty and state IDLE gives link_oe=1 after edge N+2 and dav_out=1 after edge N+3.
- Latency (ack response): ack_in rising before edge M gives dav_out=0 after edge M+2 (2 sync flops plus 1 state cycle, see worked values in the Test Plan).
- RX consume: rx_valid clears on the cycle after a handshake with rx_valid & rx_ready. rx_data holds its value until the next latch.
- Timeout:
  - A counter clears on entry to each waiting state and increments each cycle in TX_WAIT_ACK, TX_WAIT_REL and RX_WAIT_REL.
  - When the counter reaches TIMEOUT_CYCLES-1: timeout_err=1, dav_out=0, ack_out=0, link_oe=0, go to IDLE.
  - TX timeout: the head byte is popped (discarded).
  - RX timeout: the received byte is kept.
- timeout_err clears on err_clear. If a new timeout and err_clear occur in the same cycle, the set wins.
- Invariant: link_oe=1 and ack_out=1 never occur together.

Test Plan:
- Reset then idle: all outputs at reset values. tx_valid=0, dav_in=0 for 20 cycles -> busy=0, link_oe=0.
- Single TX: push 0xA5. Peer raises ack_in 3 cycles after seeing dav_out, then drops it 3 cycles after dav_out falls. Required: link_dout=0xA5 with link_oe=1 from TX_SETUP onward; dav_out falls 2 edges after ack_in rises; FIFO empty; busy=0.
- FIFO full: push 4 bytes 0x01..0x04 with ack_in held low -> tx_ready=0 after the 4th push. Release the handshake -> bytes leave in order 0x01..0x04 and tx_ready returns to 1.
- RX with backpressure: peer sends 0x3C with rx_ready=0 -> rx_data=0x3C, rx_valid=1, ack_out=1 until dav_in falls. A second dav_in with 0x7E while rx_valid=1 -> ack_out stays 0. Pulse rx_ready -> 0x7E latched and acked.
- Simultaneous: dav_in high and FIFO non-empty in the same IDLE cycle -> RX is served first (link_oe stays 0); TX starts only after dav_s=0.
- Timeout: TIMEOUT_CYCLES=8, push 0x55, ack_in never asserted -> timeout_err=1 and dav_out=0 on the 8th TX_WAIT_ACK cycle; FIFO empty. err_clear -> timeout_err=0.

Source files
------------

// File: rtl/tpi_link_xfer_if.sv
// Bundle of host-side stream and link-pin signals for the TPI byte-transfer engine.
// Host streams: a beat transfers on a clock edge where valid & ready are both 1; valid must
// hold with stable data until then, and ready may change freely between edges.
interface tpi_link_xfer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] link_din;
  logic [7:0] link_dout;
  logic       link_oe;
  logic       dav_out;
  logic       ack_in;
  logic       dav_in;
  logic       ack_out;
  logic       busy;
  logic       timeout_err;
  logic       err_clear;

  modport master (
    output tx_data, tx_valid, rx_ready, link_din, ack_in, dav_in, err_clear,
    input  tx_ready, rx_data, rx_valid, link_dout, link_oe, dav_out, ack_out, busy, timeout_err
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, link_din, ack_in, dav_in, err_clear,
    output tx_ready, rx_data, rx_valid, link_dout, link_oe, dav_out, ack_out, busy, timeout_err
  );
endinterface

// File: rtl/tpi_link_xfer.sv
// Half-duplex 4-phase DAV/ACK link engine: TX FIFO to the peer, single-entry RX register
// from the peer, with a per-phase timeout and sticky error flag.
module tpi_link_xfer #(
  parameter int TX_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clock,
  input  logic           reset,
  tpi_link_xfer_if.slave bus,
  output logic [2:0]     dbg_state
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    TX_SETUP    = 3'd1,
    TX_WAIT_ACK = 3'd2,
    TX_WAIT_REL = 3'd3,
    RX_WAIT_REL = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          ack_m_q, ack_s_q, dav_m_q, dav_s_q;
  logic [7:0]    mem_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    rx_data_q, rx_data_d, link_dout_q, link_dout_d;
  logic          tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
  logic          link_oe_q, link_oe_d, dav_out_q, dav_out_d, ack_out_q, ack_out_d;
  logic          busy_q, busy_d, err_q, err_d;
  logic          push, pop, waiting, exit_ok, tmo_fire;

  // A phase that completes on the same cycle the counter expires is treated as completed.
  assign push     = bus.tx_valid & tx_ready_q;
  assign waiting  = (state_q == TX_WAIT_ACK) || (state_q == TX_WAIT_REL) || (state_q == RX_WAIT_REL);
  assign exit_ok  = ((state_q == TX_WAIT_ACK) &&  ack_s_q) ||
                    ((state_q == TX_WAIT_REL) && !ack_s_q) ||
                    ((state_q == RX_WAIT_REL) && !dav_s_q);
  assign tmo_fire = waiting && !exit_ok && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dav_s_q && !rx_valid_q)          state_d = RX_WAIT_REL;
        else if (!dav_s_q && count_q != '0)  state_d = TX_SETUP;
      end
      TX_SETUP:    state_d = TX_WAIT_ACK;
      TX_WAIT_ACK: begin
        if (ack_s_q)       state_d = TX_WAIT_REL;
        else if (tmo_fire) state_d = IDLE;
      end
      TX_WAIT_REL,
      RX_WAIT_REL: if (exit_ok || tmo_fire) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Outputs are registered, so each is computed here as the value for the next cycle.
  always_comb begin
    link_oe_d   = 1'b0;
    dav_out_d   = 1'b0;
    ack_out_d   = 1'b0;
    pop         = 1'b0;
    link_dout_d = link_dout_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~bus.rx_ready;
    err_d       = tmo_fire | (err_q & ~bus.err_clear);
    busy_d      = (state_d != IDLE);
    tmo_cnt_d   = '0;
    if (waiting && state_d == state_q) tmo_cnt_d = tmo_cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (dav_s_q && !rx_valid_q) begin
          rx_data_d  = bus.link_din;
          rx_valid_d = 1'b1;
          ack_out_d  = 1'b1;
        end
      end
      TX_SETUP: begin
        link_oe_d   = 1'b1;
        link_dout_d = mem_q[rd_ptr_q];
      end
      TX_WAIT_ACK: begin
        link_oe_d = ~tmo_fire;
        dav_out_d = ~ack_s_q & ~tmo_fire;
        pop       = tmo_fire;
      end
      TX_WAIT_REL: begin
        link_oe_d = ack_s_q & ~tmo_fire;
        pop       = ~ack_s_q | tmo_fire;
      end
      RX_WAIT_REL: ack_out_d = dav_s_q & ~tmo_fire;
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (pop && !push) count_d = count_q - (PW+1)'(1);
    tx_ready_d = (count_d != (PW+1)'(TX_DEPTH));
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_m_q     <= 1'b0;
      ack_s_q     <= 1'b0;
      dav_m_q     <= 1'b0;
      dav_s_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmo_cnt_q   <= '0;
      rx_data_q   <= '0;
      link_dout_q <= '0;
      tx_ready_q  <= 1'b1;
      rx_valid_q  <= 1'b0;
      link_oe_q   <= 1'b0;
      dav_out_q   <= 1'b0;
      ack_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ack_m_q     <= bus.ack_in;
      ack_s_q     <= ack_m_q;
      dav_m_q     <= bus.dav_in;
      dav_s_q     <= dav_m_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rx_data_q   <= rx_data_d;
      link_dout_q <= link_dout_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      link_oe_q   <= link_oe_d;
      dav_out_q   <= dav_out_d;
      ack_out_q   <= ack_out_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.link_dout   = link_dout_q;
  assign bus.link_oe     = link_oe_q;
  assign bus.dav_out     = dav_out_q;
  assign bus.ack_out     = ack_out_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_tpi_link_xfer.sv
// Bench for tpi_link_xfer: directed latency/backpressure/timeout cases, then randomized
// two-way traffic scored against byte queues.
module tb_tpi_link_xfer;
  localparam int S_ACK  = 0;
  localparam int S_DAV  = 1;
  localparam int S_BUSY = 2;
  localparam int S_RDY  = 3;

  logic       clock;
  logic       reset;
  logic [2:0] dbg_state;
  tpi_link_xfer_if bus ();

  tpi_link_xfer #(.TX_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_errors = 0;
  bit         peer_tx_en = 1'b0;
  bit         cons_en = 1'b0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      S_ACK:   return bus.ack_out;
      S_DAV:   return bus.dav_out;
      S_BUSY:  return bus.busy;
      S_RDY:   return bus.tx_ready;
      default: return bus.rx_valid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (pick(sel) == lvl) break;
      @(negedge clock);
    end
    check(tag, pick(sel), lvl);
  endtask

  task automatic invariant_mon();
    forever begin
      @(negedge clock);
      check("oe_ack_exclusive", bus.link_oe & bus.ack_out, 1'b0);
    end
  endtask

  // Peer receiver: answers every DAV with ACK after a short random delay.
  task automatic peer_tx_loop();
    forever begin
      @(negedge clock);
      if (peer_tx_en && bus.dav_out && !bus.ack_in) begin
        check("peer_oe", bus.link_oe, 1'b1);
        check("tx_pending", exp_tx_q.size() != 0, 1'b1);
        if (exp_tx_q.size() != 0) check("tx_byte", bus.link_dout, exp_tx_q.pop_front());
        repeat ($urandom_range(0, 2)) @(negedge clock);
        bus.ack_in = 1'b1;
        for (int i = 0; i < 40 && bus.dav_out; i++) @(negedge clock);
        check("peer_dav_fall", bus.dav_out, 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        bus.ack_in = 1'b0;
      end
    end
  endtask

  task automatic consumer_loop();
    forever begin
      @(negedge clock);
      if (cons_en) begin
        bus.rx_ready = ($urandom_range(0, 2) == 0);
        if (bus.rx_ready && bus.rx_valid) begin
          check("rx_pending", exp_rx_q.size() != 0, 1'b1);
          if (exp_rx_q.size() != 0) check("rx_byte", bus.rx_data, exp_rx_q.pop_front());
        end
      end
    end
  endtask

  task automatic push_loop(input int n);
    int sent = 0;
    for (int it = 0; it < 3000 && sent < n; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        bus.tx_data  = 8'($urandom);
        bus.tx_valid = 1'b1;
        if (bus.tx_ready) begin
          exp_tx_q.push_back(bus.tx_data);
          sent++;
        end
      end else begin
        bus.tx_valid = 1'b0;
      end
      @(negedge clock);
    end
    bus.tx_valid = 1'b0;
  endtask

  task automatic rx_sender(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clock);
      b = 8'($urandom);
      bus.link_din = b;
      bus.dav_in   = 1'b1;
      exp_rx_q.push_back(b);
      wait_for(S_ACK, 1'b1, 3000, "rnd_rx_ack_rise");
      repeat ($urandom_range(0, 2)) @(negedge clock);
      bus.dav_in = 1'b0;
      wait_for(S_ACK, 1'b0, 40, "rnd_rx_ack_fall");
    end
  endtask

  initial begin
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0; bus.link_din = 8'h00;
    bus.ack_in = 1'b0; bus.dav_in = 1'b0; bus.err_clear = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_tx_ready", bus.tx_ready, 1'b1);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_link_oe", bus.link_oe, 1'b0);
    check("rst_link_dout", bus.link_dout, 8'h00);
    check("rst_dav_out", bus.dav_out, 1'b0);
    check("rst_ack_out", bus.ack_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_timeout_err", bus.timeout_err, 1'b0);
    reset = 1'b0;
    fork
      invariant_mon();
      peer_tx_loop();
      consumer_loop();
    join_none
    repeat (20) @(negedge clock);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_link_oe", bus.link_oe, 1'b0);

    // Single TX with exact latencies.
    bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
    @(negedge clock);
    bus.tx_valid = 1'b0;
    check("tx1_n_busy", bus.busy, 1'b0);
    @(negedge clock);
    check("tx1_n1_busy", bus.busy, 1'b1);
    check("tx1_n1_oe", bus.link_oe, 1'b0);
    @(negedge clock);
    check("tx1_n2_oe", bus.link_oe, 1'b1);
    check("tx1_n2_dout", bus.link_dout, 8'hA5);
    check("tx1_n2_dav", bus.dav_out, 1'b0);
    @(negedge clock);
    check("tx1_n3_dav", bus.dav_out, 1'b1);
    repeat (3) @(negedge clock);
    bus.ack_in = 1'b1;
    repeat (2) @(negedge clock);
    check("tx1_m1_dav", bus.dav_out, 1'b1);
    @(negedge clock);
    check("tx1_m2_dav", bus.dav_out, 1'b0);
    check("tx1_m2_oe", bus.link_oe, 1'b1);
    check("tx1_m2_dout", bus.link_dout, 8'hA5);
    repeat (3) @(negedge clock);
    bus.ack_in = 1'b0;
    wait_for(S_BUSY, 1'b0, 20, "tx1_done");
    check("tx1_oe_off", bus.link_oe, 1'b0);
    check("tx1_ready", bus.tx_ready, 1'b1);
    repeat (5) @(negedge clock);
    check("tx1_fifo_empty", bus.busy, 1'b0);

    // FIFO full, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      bus.tx_data = 8'(i); bus.tx_valid = 1'b1;
      @(negedge clock);
    end
    bus.tx_valid = 1'b0;
    check("full_tx_ready", bus.tx_ready, 1'b0);
    for (int i = 1; i <= 4; i++) exp_tx_q.push_back(8'(i));
    peer_tx_en = 1'b1;
    for (int i = 0; i < 300 && (exp_tx_q.size() != 0 || bus.busy); i++) @(negedge clock);
    check("full_drained", exp_tx_q.size(), 0);
    check("full_ready_back", bus.tx_ready, 1'b1);
    check("full_timeout_err", bus.timeout_err, 1'b0);
    peer_tx_en = 1'b0;

    // RX with backpressure.
    bus.link_din = 8'h3C; bus.dav_in = 1'b1;
    wait_for(S_ACK, 1'b1, 10, "rx1_ack");
    check("rx1_valid", bus.rx_valid, 1'b1);
    check("rx1_data", bus.rx_data, 8'h3C);
    check("rx1_oe", bus.link_oe, 1'b0);
    @(negedge clock);
    check("rx1_ack_hold", bus.ack_out, 1'b1);
    bus.dav_in = 1'b0; bus.link_din = 8'h00;
    wait_for(S_ACK, 1'b0, 10, "rx1_ack_rel");
    check("rx1_valid_kept", bus.rx_valid, 1'b1);
    bus.link_din = 8'h7E; bus.dav_in = 1'b1;
    repeat (10) @(negedge clock);
    check("rx2_no_ack", bus.ack_out, 1'b0);
    check("rx2_data_held", bus.rx_data, 8'h3C);
    check("rx2_not_busy", bus.busy, 1'b0);
    bus.rx_ready = 1'b1;
    @(negedge clock);
    bus.rx_ready = 1'b0;
    check("rx1_consumed", bus.rx_valid, 1'b0);
    wait_for(S_ACK, 1'b1, 10, "rx2_ack");
    check("rx2_data", bus.rx_data, 8'h7E);
    bus.dav_in = 1'b0;
    wait_for(S_ACK, 1'b0, 10, "rx2_ack_rel");
    bus.rx_ready = 1'b1;
    @(negedge clock);
    bus.rx_ready = 1'b0;
    check("rx2_consumed", bus.rx_valid, 1'b0);

    // RX and TX requests together: RX goes first.
    bus.link_din = 8'h96; bus.dav_in = 1'b1;
    @(negedge clock);
    bus.tx_data = 8'h4B; bus.tx_valid = 1'b1;
    @(negedge clock);
    bus.tx_valid = 1'b0;
    @(negedge clock);
    check("sim_ack", bus.ack_out, 1'b1);
    check("sim_oe", bus.link_oe, 1'b0);
    check("sim_rx_data", bus.rx_data, 8'h96);
    exp_tx_q.push_back(8'h4B);
    peer_tx_en = 1'b1;
    bus.dav_in = 1'b0;
    wait_for(S_ACK, 1'b0, 10, "sim_ack_rel");
    check("sim_oe_after_rx", bus.link_oe, 1'b0);
    for (int i = 0; i < 100 && (exp_tx_q.size() != 0 || bus.busy); i++) @(negedge clock);
    check("sim_tx_done", exp_tx_q.size(), 0);
    peer_tx_en = 1'b0;
    bus.rx_ready = 1'b1;
    @(negedge clock);
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clock);

    // TX timeout with no ACK.
    bus.tx_data = 8'h55; bus.tx_valid = 1'b1;
    @(negedge clock);
    bus.tx_valid = 1'b0;
    repeat (9) @(negedge clock);
    check("tmo_pre_dav", bus.dav_out, 1'b1);
    check("tmo_pre_err", bus.timeout_err, 1'b0);
    @(negedge clock);
    check("tmo_err", bus.timeout_err, 1'b1);
    check("tmo_dav", bus.dav_out, 1'b0);
    check("tmo_oe", bus.link_oe, 1'b0);
    check("tmo_busy", bus.busy, 1'b0);
    repeat (5) @(negedge clock);
    check("tmo_no_restart", bus.link_oe, 1'b0);
    check("tmo_fifo_empty", bus.tx_ready, 1'b1);
    check("tmo_sticky", bus.timeout_err, 1'b1);
    bus.err_clear = 1'b1;
    @(negedge clock);
    bus.err_clear = 1'b0;
    check("tmo_cleared", bus.timeout_err, 1'b0);

    // Randomized bidirectional traffic.
    peer_tx_en = 1'b1;
    cons_en    = 1'b1;
    fork
      push_loop(24);
      rx_sender(24);
    join
    for (int i = 0; i < 2000 && (exp_tx_q.size() != 0 || exp_rx_q.size() != 0 ||
                                 bus.busy || bus.rx_valid); i++) @(negedge clock);
    check("rnd_tx_drained", exp_tx_q.size(), 0);
    check("rnd_rx_drained", exp_rx_q.size(), 0);
    check("rnd_timeout_err", bus.timeout_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
